// File: rtl/result_reporter.sv
// result_reporter
//   Captures a core's completion result once, converts it to decimal with a
//   double-dabble shifter and transmits "RESULT: <decimal>\r\n" as 8N1 UART
//   frames, back to back.
//
// Parameters
//   WIDTH         bit width of sum (4..32)
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   isEnd  in   core completion flag (level)
//   sum    in   core result, unsigned, valid while isEnd is high
//   txd    out  UART serial output, idle high
//   busy   out  high from capture until the last stop bit completes
//   done   out  high once the full line has been sent, sticky until reset
module result_reporter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             isEnd,
    input  logic [WIDTH-1:0] sum,
    output logic             txd,
    output logic             busy,
    output logic             done
);

    // ceil(WIDTH * log10(2)); log10(2) is irrational so no exact-integer edge case
    localparam int unsigned NDIG = (WIDTH * 30103 + 99999) / 100000;
    localparam int unsigned BCDW = 4 * NDIG;
    localparam int unsigned MAXCH = 10 + NDIG;
    localparam int unsigned CHW = $clog2(MAXCH + 1);
    localparam int unsigned SCW = $clog2(WIDTH);
    localparam int unsigned CKW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {StIdle, StConvert, StSend, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] cap_q, cap_d;
    logic [BCDW-1:0]  bcd_q, bcd_d;
    logic [SCW-1:0]   shift_cnt_q, shift_cnt_d;
    logic             lead_q, lead_d;
    logic [CHW-1:0]   lz_q, lz_d;
    logic [CHW-1:0]   char_q, char_d;
    logic [3:0]       bit_q, bit_d;
    logic [CKW-1:0]   clk_cnt_q, clk_cnt_d;

    logic [BCDW-1:0]  bcd_adj;
    logic [CHW-1:0]   lz_calc;
    logic [CHW-1:0]   line_last;
    logic [CHW-1:0]   line_cr;
    logic [7:0]       cur_char;
    logic             tx_bit;
    logic             conv_last;
    logic             bit_end;
    logic             frame_last;

    // Index of the LF character; the line has 8 + (NDIG - lz) + 2 characters
    assign line_last = CHW'(9 + NDIG) - lz_q;
    assign line_cr   = line_last - CHW'(1);

    assign conv_last  = (shift_cnt_q == SCW'(WIDTH - 1));
    assign bit_end    = (clk_cnt_q == CKW'(CLKS_PER_BIT - 1));
    assign frame_last = !lead_q && bit_end && (bit_q == 4'd9) && (char_q == line_last);

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Leading-zero digit count; the least significant digit is always sent
    always_comb begin
        logic found;
        lz_calc = '0;
        found   = 1'b0;
        for (int i = int'(NDIG) - 1; i >= 1; i--) begin
            if (!found && (bcd_q[4*i +: 4] == 4'd0)) begin
                lz_calc = lz_calc + CHW'(1);
            end else begin
                found = 1'b1;
            end
        end
    end

    // Character currently on the wire
    always_comb begin
        int dig_idx;
        cur_char = 8'h00;
        dig_idx  = 0;
        if (char_q < CHW'(8)) begin
            unique case (char_q[2:0])
                3'd0: cur_char = 8'h52;
                3'd1: cur_char = 8'h45;
                3'd2: cur_char = 8'h53;
                3'd3: cur_char = 8'h55;
                3'd4: cur_char = 8'h4C;
                3'd5: cur_char = 8'h54;
                3'd6: cur_char = 8'h3A;
                3'd7: cur_char = 8'h20;
            endcase
        end else if (char_q == line_cr) begin
            cur_char = 8'h0D;
        end else if (char_q == line_last) begin
            cur_char = 8'h0A;
        end else begin
            // Digit position counted from the most significant end, skipping zeros
            dig_idx = int'(NDIG) - 1 - int'(lz_q) - int'(char_q) + 8;
            for (int i = 0; i < int'(NDIG); i++) begin
                if (i == dig_idx) begin
                    cur_char = {4'h3, bcd_q[4*i +: 4]};
                end
            end
        end
    end

    // Frame bit: 0 = start, 1..8 = data LSB first, 9 = stop
    always_comb begin
        tx_bit = 1'b1;
        if (bit_q == 4'd0) begin
            tx_bit = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (bit_q == 4'(i + 1)) begin
                    tx_bit = cur_char[i];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (isEnd) state_d = StConvert;
            StConvert: if (conv_last) state_d = StSend;
            StSend:    if (frame_last) state_d = StDone;
            StDone:    state_d = StDone;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        txd  = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            StConvert: busy = 1'b1;
            StSend: begin
                busy = 1'b1;
                txd  = lead_q ? 1'b1 : tx_bit;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cap_d       = cap_q;
        bcd_d       = bcd_q;
        shift_cnt_d = shift_cnt_q;
        lead_d      = lead_q;
        lz_d        = lz_q;
        char_d      = char_q;
        bit_d       = bit_q;
        clk_cnt_d   = clk_cnt_q;
        case (state_q)
            StIdle: begin
                if (isEnd) begin
                    cap_d       = sum;
                    bcd_d       = '0;
                    shift_cnt_d = '0;
                end
            end
            StConvert: begin
                bcd_d       = {bcd_adj[BCDW-2:0], cap_q[WIDTH-1]};
                cap_d       = cap_q << 1;
                shift_cnt_d = shift_cnt_q + SCW'(1);
                if (conv_last) begin
                    lead_d    = 1'b1;
                    char_d    = '0;
                    bit_d     = '0;
                    clk_cnt_d = '0;
                end
            end
            StSend: begin
                if (lead_q) begin
                    // One idle-high cycle lets the final BCD settle before
                    // the leading-zero count is registered
                    lead_d = 1'b0;
                    lz_d   = lz_calc;
                end else if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d  = '0;
                        char_d = char_q + CHW'(1);
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CKW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q       <= '0;
            bcd_q       <= '0;
            shift_cnt_q <= '0;
            lead_q      <= 1'b0;
            lz_q        <= '0;
            char_q      <= '0;
            bit_q       <= '0;
            clk_cnt_q   <= '0;
        end else begin
            cap_q       <= cap_d;
            bcd_q       <= bcd_d;
            shift_cnt_q <= shift_cnt_d;
            lead_q      <= lead_d;
            lz_q        <= lz_d;
            char_q      <= char_d;
            bit_q       <= bit_d;
            clk_cnt_q   <= clk_cnt_d;
        end
    end

endmodule
